// File: rtl/arrow_lane_scheduler.sv
// arrow_lane_scheduler: two-player arrow lanes scrolled every FRAMES_PER_STEP vsync ticks, note fetch via note_valid/note_ready, press judgement, indicators and scores
module arrow_lane_scheduler #(
  parameter int FRAMES_PER_STEP = 4,
  parameter int HOLD_FRAMES = 30
) (
  input  logic clock,
  input  logic reset,
  input  logic vs_n,
  input  logic run,
  input  logic note_valid,
  input  logic [2:0] note_p1,
  input  logic [2:0] note_p2,
  output logic note_ready,
  input  logic [3:0] p1_btn,
  input  logic [3:0] p2_btn,
  output logic [77:0] player1_indexes,
  output logic [77:0] player2_indexes,
  output logic [1:0] player1_good_bad,
  output logic [1:0] player2_good_bad,
  output logic [7:0] p1_score,
  output logic [7:0] p2_score
);
  logic vs_q, tick, step;
  logic [7:0] cnt;
  logic [1:0][2:0] note;
  logic [1:0][3:0] btn;
  logic [1:0][77:0] lanes;
  logic [1:0][1:0] gbs;
  logic [1:0][7:0] scores;
  assign note = {note_p2, note_p1};
  assign btn = {p2_btn, p1_btn};
  assign {player2_indexes, player1_indexes} = lanes;
  assign {player2_good_bad, player1_good_bad} = gbs;
  assign {p2_score, p1_score} = scores;
  assign tick = vs_q & ~vs_n;
  assign step = tick & run & (cnt == 8'(FRAMES_PER_STEP - 1));
  assign note_ready = step;
  always_ff @(posedge clock)
    if (reset) begin
      vs_q <= 1'b0;
      cnt <= 8'd0;
    end else begin
      vs_q <= vs_n;
      if (tick & run) cnt <= step ? 8'd0 : cnt + 8'd1;
    end
  for (genvar i = 0; i < 2; i++) begin : g_p
    logic [77:0] lane;
    logic [1:0] gb;
    logic [7:0] score, hold;
    logic [2:0] s0, nc;
    logic [3:0] want;
    logic hit, bad, miss;
    always_comb begin
      s0 = lane[2:0];
      want = s0 == 3'd1 ? 4'b0001 : s0 == 3'd2 ? 4'b0010 : s0 == 3'd3 ? 4'b0100 : s0 == 3'd4 ? 4'b1000 : 4'b0000;
      nc = (note_valid && note[i] <= 3'd4) ? note[i] : 3'd0;
      hit = run && btn[i] != 4'd0 && btn[i] == want;
      bad = run && btn[i] != 4'd0 && !hit;
      miss = step && s0 != 3'd0 && !hit;
    end
    always_ff @(posedge clock)
      if (reset) begin
        lane <= '0;
        gb <= 2'b00;
        score <= 8'd0;
        hold <= 8'd0;
      end else begin
        if (step) lane <= {nc, lane[77:3]};
        else if (hit) lane[2:0] <= 3'd0;
        if (hit && score != 8'hff) score <= score + 8'd1;
        if (hit | bad | miss) begin
          gb <= hit ? 2'b01 : 2'b10;
          hold <= 8'(HOLD_FRAMES);
        end else if (tick && hold != 8'd0) begin
          hold <= hold - 8'd1;
          if (hold == 8'd1) gb <= 2'b00;
        end
      end
    assign lanes[i] = lane;
    assign gbs[i] = gb;
    assign scores[i] = score;
  end
endmodule

// File: tb/tb_arrow_lane_scheduler.sv
// tb_arrow_lane_scheduler: directed and random checks of arrow_lane_scheduler against a slot-array model
module tb_arrow_lane_scheduler;
  localparam int FPS = 4, HOLD = 30;
  logic clock = 1'b0;
  logic reset, vs_n, run, note_valid, note_ready;
  logic [2:0] note_p1, note_p2;
  logic [3:0] p1_btn, p2_btn;
  logic [77:0] player1_indexes, player2_indexes;
  logic [1:0] player1_good_bad, player2_good_bad;
  logic [7:0] p1_score, p2_score;
  int checks = 0, errors = 0, pulses = 0;
  int m_vsq, m_cnt, m_gb[2], m_score[2], m_hold[2];
  int m_lane[2][26];
  always #5 clock = ~clock;
  arrow_lane_scheduler #(.FRAMES_PER_STEP(FPS), .HOLD_FRAMES(HOLD)) dut (
    .clock(clock), .reset(reset), .vs_n(vs_n), .run(run), .note_valid(note_valid),
    .note_p1(note_p1), .note_p2(note_p2), .note_ready(note_ready),
    .p1_btn(p1_btn), .p2_btn(p2_btn),
    .player1_indexes(player1_indexes), .player2_indexes(player2_indexes),
    .player1_good_bad(player1_good_bad), .player2_good_bad(player2_good_bad),
    .p1_score(p1_score), .p2_score(p2_score)
  );
  task automatic chk(input string tag, input logic [77:0] obs, input logic [77:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [3:0] want(input int c);
    return (c >= 1 && c <= 4) ? 4'(1 << (c - 1)) : 4'd0;
  endfunction
  function automatic logic [77:0] pack(input int p);
    logic [77:0] v = '0;
    for (int k = 0; k < 26; k++) v[3*k +: 3] = 3'(m_lane[p][k]);
    return v;
  endfunction
  function automatic void upd(input bit tick, input bit step);
    logic [3:0] b [2];
    int n [2];
    b[0] = p1_btn; b[1] = p2_btn;
    n[0] = int'(note_p1); n[1] = int'(note_p2);
    if (reset) begin
      m_vsq = 0; m_cnt = 0;
      for (int p = 0; p < 2; p++) begin
        m_gb[p] = 0; m_score[p] = 0; m_hold[p] = 0;
        for (int k = 0; k < 26; k++) m_lane[p][k] = 0;
      end
      return;
    end
    for (int p = 0; p < 2; p++) begin
      int s0;
      bit hit, bad, miss;
      s0 = m_lane[p][0];
      hit = run && b[p] != 0 && b[p] == want(s0);
      bad = run && b[p] != 0 && !hit;
      miss = step && s0 != 0 && !hit;
      if (hit && m_score[p] < 255) m_score[p]++;
      if (hit || bad || miss) begin
        m_gb[p] = hit ? 1 : 2;
        m_hold[p] = HOLD;
      end else if (tick && m_hold[p] > 0) begin
        m_hold[p]--;
        if (m_hold[p] == 0) m_gb[p] = 0;
      end
      if (step) begin
        for (int k = 0; k < 25; k++) m_lane[p][k] = m_lane[p][k+1];
        m_lane[p][25] = (note_valid && n[p] <= 4) ? n[p] : 0;
      end else if (hit) m_lane[p][0] = 0;
    end
    if (tick && run) m_cnt = step ? 0 : m_cnt + 1;
    m_vsq = int'(vs_n);
  endfunction
  task automatic cyc();
    bit tick, step;
    tick = m_vsq == 1 && vs_n == 1'b0;
    step = tick && run && m_cnt == FPS - 1;
    #1;
    chk("note_ready", 78'(note_ready), 78'(step));
    if (note_ready) pulses++;
    @(posedge clock);
    upd(tick, step);
    #1;
    chk("p1_lane", player1_indexes, pack(0));
    chk("p2_lane", player2_indexes, pack(1));
    chk("p1_gb", 78'(player1_good_bad), 78'(m_gb[0]));
    chk("p2_gb", 78'(player2_good_bad), 78'(m_gb[1]));
    chk("p1_score", 78'(p1_score), 78'(m_score[0]));
    chk("p2_score", 78'(p2_score), 78'(m_score[1]));
  endtask
  task automatic frame();
    vs_n = 1'b1; cyc(); cyc();
    vs_n = 1'b0; cyc(); cyc();
  endtask
  task automatic sat_cyc(input int c);
    vs_n = 1'((c / 2) % 2);
    note_p1 = 3'($urandom_range(1, 4));
    note_p2 = 3'($urandom);
    p1_btn = want(m_lane[0][0]);
    cyc();
  endtask
  initial begin
    reset = 1'b1; vs_n = 1'b1; run = 1'b0; note_valid = 1'b0;
    note_p1 = 3'd0; note_p2 = 3'd0; p1_btn = 4'd0; p2_btn = 4'd0;
    cyc(); cyc();
    chk("rst_lane1", player1_indexes, 78'd0);
    chk("rst_lane2", player2_indexes, 78'd0);
    chk("rst_gb", 78'({player1_good_bad, player2_good_bad}), 78'd0);
    chk("rst_score", 78'({p1_score, p2_score}), 78'd0);
    chk("rst_ready", 78'(note_ready), 78'd0);
    reset = 1'b0;
    run = 1'b1; note_valid = 1'b1; note_p1 = 3'd3; note_p2 = 3'd4; pulses = 0;
    repeat (4) frame();
    chk("scroll_pulses", 78'(pulses), 78'd1);
    chk("p1_top", 78'(player1_indexes[77:75]), 78'd3);
    chk("p2_top", 78'(player2_indexes[77:75]), 78'd4);
    note_valid = 1'b0;
    repeat (25 * FPS) frame();
    chk("p1_bottom", 78'(player1_indexes[2:0]), 78'd3);
    chk("p2_bottom", 78'(player2_indexes[2:0]), 78'd4);
    vs_n = 1'b1; p1_btn = 4'b0100; cyc(); p1_btn = 4'd0;
    chk("hit_slot0", 78'(player1_indexes[2:0]), 78'd0);
    chk("hit_gb", 78'(player1_good_bad), 78'd1);
    chk("hit_score", 78'(p1_score), 78'd1);
    run = 1'b0; pulses = 0;
    repeat (HOLD - 1) begin
      vs_n = 1'b1; p1_btn = 4'($urandom); p2_btn = 4'($urandom); cyc();
      vs_n = 1'b0; p1_btn = 4'($urandom); p2_btn = 4'($urandom); cyc();
    end
    p1_btn = 4'd0; p2_btn = 4'd0;
    chk("pause_pulses", 78'(pulses), 78'd0);
    chk("hold_29", 78'(player1_good_bad), 78'd1);
    chk("pause_p2_frozen", 78'(player2_indexes[2:0]), 78'd4);
    frame();
    chk("hold_30", 78'(player1_good_bad), 78'd0);
    run = 1'b1;
    for (int g = 0; g < 8 && m_cnt != 0; g++) frame();
    repeat (FPS) frame();
    chk("miss_gb", 78'(player2_good_bad), 78'd2);
    chk("miss_score", 78'(p2_score), 78'd0);
    repeat (5) frame();
    vs_n = 1'b1; p2_btn = 4'b0011; cyc(); p2_btn = 4'd0;
    chk("bad_gb", 78'(player2_good_bad), 78'd2);
    repeat (HOLD - 1) frame();
    chk("reload_29", 78'(player2_good_bad), 78'd2);
    frame();
    chk("reload_30", 78'(player2_good_bad), 78'd0);
    for (int g = 0; g < 8 && m_cnt != 0; g++) frame();
    note_valid = 1'b1; note_p1 = 3'd4; note_p2 = 3'd6;
    repeat (FPS) frame();
    chk("sanitised_top", 78'(player2_indexes[77:75]), 78'd0);
    note_valid = 1'b0;
    repeat (25 * FPS) frame();
    chk("simul_pre", 78'(player1_indexes[2:0]), 78'd4);
    pulses = 0;
    repeat (FPS - 1) frame();
    vs_n = 1'b1; cyc(); cyc();
    vs_n = 1'b0; p1_btn = 4'b1000; cyc(); p1_btn = 4'd0; cyc();
    chk("simul_pulses", 78'(pulses), 78'd1);
    chk("simul_gb", 78'(player1_good_bad), 78'd1);
    chk("simul_score", 78'(p1_score), 78'd2);
    chk("simul_slot0", 78'(player1_indexes[2:0]), 78'd0);
    for (int c = 0; c < 2000; c++) begin
      reset = ($urandom % 300) == 0;
      vs_n = 1'($urandom);
      run = ($urandom % 8) != 0;
      note_valid = 1'($urandom);
      note_p1 = 3'($urandom); note_p2 = 3'($urandom);
      p1_btn = ($urandom % 10) < 5 ? 4'd0 : ($urandom % 3) != 0 ? want(m_lane[0][0]) : 4'($urandom);
      p2_btn = ($urandom % 10) < 5 ? 4'd0 : ($urandom % 3) != 0 ? want(m_lane[1][0]) : 4'($urandom);
      cyc();
    end
    reset = 1'b0; run = 1'b1; note_valid = 1'b1; p2_btn = 4'd0;
    for (int c = 0; c < 20000 && m_score[0] < 255; c++) sat_cyc(c);
    for (int c = 0; c < 64; c++) sat_cyc(c);
    chk("sat_score", 78'(p1_score), 78'd255);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
